// File: rtl/psg_pkg.sv
// rtl/psg_pkg.sv - shared types and constants for the PSG envelope generator
package psg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam logic [1:0] CFG_ATTACK  = 2'd0;
  localparam logic [1:0] CFG_DECAY   = 2'd1;
  localparam logic [1:0] CFG_SUSTAIN = 2'd2;
  localparam logic [1:0] CFG_RELEASE = 2'd3;

  localparam int VOL_BASE = 8;
  localparam int EN_REG   = 15;

  localparam logic [7:0] ATTACK_DEF  = 8'd16;
  localparam logic [7:0] DECAY_DEF   = 8'd4;
  localparam logic [7:0] SUSTAIN_DEF = 8'd128;
  localparam logic [7:0] RELEASE_DEF = 8'd8;

endpackage

// File: rtl/env_voice.sv
// rtl/env_voice.sv - one ADSR voice: phase FSM, saturating level, write requests
module env_voice
  import psg_pkg::*;
#(
  parameter int OUT_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_on,
  input  logic       key_off,
  input  logic [7:0] attack_step,
  input  logic [7:0] decay_step,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_step,
  output logic [7:0] level,
  output logic       active,
  output logic       vol_dirty,
  output logic       active_chg
);

  env_state_t state, next_state;
  logic [7:0] next_level;
  logic [8:0] sum, diff_dec, diff_rel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      level <= '0;
    end else begin
      state <= next_state;
      level <= next_level;
    end
  end

  // Key events pre-empt the level step; the ninth bit catches overflow and borrow.
  always_comb begin
    next_state = state;
    next_level = level;
    sum        = {1'b0, level} + {1'b0, attack_step};
    diff_dec   = {1'b0, level} - {1'b0, decay_step};
    diff_rel   = {1'b0, level} - {1'b0, release_step};
    if (key_on) begin
      next_state = ATTACK;
    end else if (key_off) begin
      if (state inside {ATTACK, DECAY, SUSTAIN})
        next_state = RELEASE;
    end else if (tick) begin
      case (state)
        ATTACK: begin
          if (attack_step == '0 || sum >= 9'd255) begin
            next_level = 8'hFF;
            next_state = DECAY;
          end else begin
            next_level = sum[7:0];
          end
        end
        DECAY: begin
          if (decay_step == '0 || diff_dec[8] || diff_dec[7:0] <= sustain_level) begin
            next_level = sustain_level;
            next_state = SUSTAIN;
          end else begin
            next_level = diff_dec[7:0];
          end
        end
        RELEASE: begin
          if (release_step == '0 || diff_rel[8] || diff_rel[7:0] == '0) begin
            next_level = '0;
            next_state = IDLE;
          end else begin
            next_level = diff_rel[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    active     = (state != IDLE);
    vol_dirty  = ((next_level >> OUT_SHIFT) != (level >> OUT_SHIFT));
    active_chg = ((next_state != IDLE) != (state != IDLE));
  end

endmodule

// File: rtl/psg_envelope_gen.sv
// rtl/psg_envelope_gen.sv - per-voice ADSR envelopes streamed to the PSG register port
module psg_envelope_gen #(
  parameter int NVOICES   = 4,
  parameter int OUT_SHIFT = 2,
  parameter int VOL_BASE  = psg_pkg::VOL_BASE,
  parameter int EN_REG    = psg_pkg::EN_REG
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [NVOICES-1:0]     key_on,
  input  logic [NVOICES-1:0]     key_off,
  input  logic [1:0]             cfg_sel,
  input  logic [7:0]             cfg_data,
  input  logic                   cfg_write,
  output logic [3:0]             psg_sel,
  output logic [7:0]             psg_data,
  output logic                   psg_write,
  output logic [8*NVOICES-1:0]   env_level
);
  import psg_pkg::*;

  localparam int PW = $clog2(NVOICES + 1);

  logic [7:0] attack_step, decay_step, sustain_level, release_step;
  logic [7:0] level [NVOICES];
  logic [NVOICES-1:0] active, vol_dirty, active_chg;
  logic [NVOICES:0] dirty, dirty_set, slot_clr;
  logic [PW-1:0] ptr;
  logic [3:0] slot_sel;
  logic [7:0] slot_data;

  // Registered config only reaches the voices on the following tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attack_step   <= ATTACK_DEF;
      decay_step    <= DECAY_DEF;
      sustain_level <= SUSTAIN_DEF;
      release_step  <= RELEASE_DEF;
    end else if (cfg_write) begin
      case (cfg_sel)
        CFG_ATTACK:  attack_step   <= cfg_data;
        CFG_DECAY:   decay_step    <= cfg_data;
        CFG_SUSTAIN: sustain_level <= cfg_data;
        default:     release_step  <= cfg_data;
      endcase
    end
  end

  for (genvar i = 0; i < NVOICES; i++) begin : g_voice
    env_voice #(.OUT_SHIFT(OUT_SHIFT)) u_voice (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .key_on        (key_on[i]),
      .key_off       (key_off[i]),
      .attack_step   (attack_step),
      .decay_step    (decay_step),
      .sustain_level (sustain_level),
      .release_step  (release_step),
      .level         (level[i]),
      .active        (active[i]),
      .vol_dirty     (vol_dirty[i]),
      .active_chg    (active_chg[i])
    );
    assign env_level[8*i +: 8] = level[i];
  end

  assign dirty_set = {|active_chg, vol_dirty};

  // Slot contents are taken from live state so the PSG sees the newest value.
  always_comb begin
    slot_sel  = 4'(EN_REG);
    slot_data = 8'(active);
    for (int i = 0; i < NVOICES; i++) begin
      if (ptr == PW'(i)) begin
        slot_sel  = 4'(VOL_BASE + i);
        slot_data = level[i] >> OUT_SHIFT;
      end
    end
    slot_clr      = '0;
    slot_clr[ptr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      dirty     <= '1;
      psg_sel   <= '0;
      psg_data  <= '0;
      psg_write <= 1'b0;
    end else begin
      ptr       <= (ptr == PW'(NVOICES)) ? '0 : ptr + PW'(1);
      psg_write <= dirty[ptr];
      if (dirty[ptr]) begin
        psg_sel  <= slot_sel;
        psg_data <= slot_data;
      end
      dirty <= (dirty & ~slot_clr) | dirty_set;
    end
  end

endmodule

// File: tb/tb_psg_envelope_gen.sv
// tb/tb_psg_envelope_gen.sv - scoreboard bench for psg_envelope_gen
module tb_psg_envelope_gen;

  localparam int NV = 4;
  localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  key_on = '0;
  logic [3:0]  key_off = '0;
  logic [1:0]  cfg_sel = '0;
  logic [7:0]  cfg_data = '0;
  logic        cfg_write = 1'b0;
  logic [3:0]  psg_sel;
  logic [7:0]  psg_data;
  logic        psg_write;
  logic [31:0] env_level;

  psg_envelope_gen #(.NVOICES(NV), .OUT_SHIFT(2), .VOL_BASE(8), .EN_REG(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .key_on    (key_on),
    .key_off   (key_off),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .cfg_write (cfg_write),
    .psg_sel   (psg_sel),
    .psg_data  (psg_data),
    .psg_write (psg_write),
    .env_level (env_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  lv[NV];
  int  st[NV];
  int  vol_seen[NV];
  int  att = 16, dec = 4, sus = 128, rel = 8;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_mask();
    int m = 0;
    for (int i = 0; i < NV; i++)
      if (st[i] != S_IDLE) m |= (1 << i);
    return m;
  endfunction

  task automatic model_step(input int i);
    case (st[i])
      S_ATT: if (att == 0 || lv[i] + att >= 255) begin lv[i] = 255; st[i] = S_DEC; end
             else lv[i] = lv[i] + att;
      S_DEC: if (dec == 0 || lv[i] - dec <= sus) begin lv[i] = sus; st[i] = S_SUS; end
             else lv[i] = lv[i] - dec;
      S_REL: if (rel == 0 || lv[i] - rel <= 0) begin lv[i] = 0; st[i] = S_IDLE; end
             else lv[i] = lv[i] - rel;
      default: ;
    endcase
  endtask

  task automatic push_wr(input int sel, input int data);
    wr_t w;
    w.sel  = sel;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // One stimulus cycle, then an idle gap long enough for a full writer lap.
  task automatic drive(input bit t, input logic [3:0] kon, input logic [3:0] koff,
                       input bit cw = 1'b0, input int cs = 0, input int cd = 0);
    int old_vol[NV];
    int old_mask;
    old_mask = model_mask();
    for (int i = 0; i < NV; i++) old_vol[i] = lv[i] >> 2;
    for (int i = 0; i < NV; i++) begin
      if (kon[i]) st[i] = S_ATT;
      else if (koff[i]) begin
        if (st[i] == S_ATT || st[i] == S_DEC || st[i] == S_SUS) st[i] = S_REL;
      end else if (t) model_step(i);
    end
    if (cw) begin
      case (cs)
        0: att = cd;
        1: dec = cd;
        2: sus = cd;
        default: rel = cd;
      endcase
    end
    for (int i = 0; i < NV; i++)
      if ((lv[i] >> 2) != old_vol[i]) push_wr(8 + i, lv[i] >> 2);
    if (model_mask() != old_mask) push_wr(15, model_mask());
    tick = t; key_on = kon; key_off = koff;
    cfg_write = cw; cfg_sel = cs[1:0]; cfg_data = cd[7:0];
    @(posedge clk); #1;
    tick = 1'b0; key_on = '0; key_off = '0; cfg_write = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++)
      check($sformatf("level_v%0d", i), int'(env_level[8*i +: 8]), lv[i]);
    check("writes_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    int idx;
    int sum;
    if (!reset && psg_write) begin
      idx = -1;
      foreach (exp_q[k])
        if (idx < 0 && exp_q[k].sel == int'(psg_sel)) idx = k;
      check($sformatf("write_reg%0d_expected", psg_sel), int'(idx >= 0), 1);
      if (idx >= 0) begin
        check($sformatf("write_reg%0d_data", psg_sel), int'(psg_data), exp_q[idx].data);
        exp_q.delete(idx);
      end
      if (int'(psg_sel) >= 8 && int'(psg_sel) < 8 + NV) begin
        vol_seen[int'(psg_sel) - 8] = int'(psg_data);
        sum = 0;
        for (int i = 0; i < NV; i++) sum += vol_seen[i];
        check("vol_sum_le_255", int'(sum <= 255), 1);
      end
    end
  end

  initial begin
    for (int i = 0; i < NV; i++) begin
      lv[i] = 0; st[i] = S_IDLE; vol_seen[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_psg_write", int'(psg_write), 0);
    check("rst_psg_sel", int'(psg_sel), 0);
    check("rst_psg_data", int'(psg_data), 0);
    check("rst_env_level", int'(env_level), 0);

    for (int i = 0; i < NV; i++) push_wr(8 + i, 0);
    push_wr(15, 0);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("reset_writes_drained", exp_q.size(), 0);
    exp_q.delete();

    // Voices 0-2 through attack and decay into sustain.
    drive(1'b0, 4'b0111, 4'b0000);
    for (int n = 0; n < 48; n++) drive(1'b1, 4'b0000, 4'b0000);

    // Voice 1 released to idle.
    drive(1'b0, 4'b0000, 4'b0010);
    for (int n = 0; n < 16; n++) drive(1'b1, 4'b0000, 4'b0000);

    // Simultaneous on/off retriggers voice 2 from its current level.
    drive(1'b0, 4'b0100, 4'b0100);
    drive(1'b1, 4'b0000, 4'b0000);

    // Config write alongside a tick uses the old step; instant attack afterwards.
    drive(1'b1, 4'b0000, 4'b0000, 1'b1, 0, 0);
    drive(1'b0, 4'b1000, 4'b0000);
    drive(1'b1, 4'b0000, 4'b0000);

    // All voices attacking together.
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 0, 16);
    drive(1'b0, 4'b1111, 4'b0000);
    for (int n = 0; n < 10; n++) drive(1'b1, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
